// File: rtl/rom_dl_wb.sv
// ROM image download bridge: packs 16-bit ioctl writes into 32-bit words, queues
// them in a small FIFO and writes them to SDRAM as a Wishbone classic master.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | bus released; start a cycle when the FIFO holds a word
//  S_REQ  | cyc/stb high, outputs frozen until wb_ack_i
//  S_GAP  | one dead cycle with cyc/stb low after each acked write
module rom_dl_wb #(
    parameter logic [25:0] BASE_ADDR = 26'h0400000,
    parameter logic [7:0]  INDEX     = 8'd1,
    parameter int          DEPTH     = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [25:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [2:0]  wb_cti_o,
    input  logic        wb_ack_i,
    output logic        dl_busy,
    output logic        dl_done,
    output logic [21:0] words_written
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LP_WAIT = CW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_active;
    logic          r_active_q;
    logic          w_active_nxt;
    logic          w_acc;

    logic [21:0]   r_asm_word;
    logic [31:0]   r_asm_data;
    logic [3:0]    r_asm_sel;
    logic          r_asm_valid;
    logic [21:0]   w_asm_word_n;
    logic [31:0]   w_asm_data_n;
    logic [3:0]    w_asm_sel_n;
    logic          w_asm_valid_n;

    logic [21:0]   w_word;
    logic [3:0]    w_lane_sel;
    logic [31:0]   w_lane_data;
    logic [3:0]    w_sel_merged;
    logic [31:0]   w_data_merged;

    logic          w_push;
    logic [57:0]   w_push_ent;
    logic          w_do_push;
    logic          w_pop;
    logic          w_load;
    logic          w_empty;

    logic [57:0]   r_fifo [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [57:0]   w_head;

    logic [3:0]    r_wb_sel;
    logic [25:0]   r_wb_adr;
    logic [31:0]   r_wb_dat;
    logic [21:0]   r_ww;
    logic          w_busy;
    logic          r_busy_q;
    logic          r_done;
    logic          w_unused;

    assign w_unused     = ^{ioctl_addr[24], ioctl_addr[0]};
    assign w_active_nxt = ioctl_download && (ioctl_index == INDEX);
    assign w_acc        = ioctl_wr && r_active;
    assign w_word       = ioctl_addr[23:2];
    assign w_lane_sel   = ioctl_addr[1] ? 4'b1100 : 4'b0011;
    assign w_lane_data  = ioctl_addr[1] ? {ioctl_dout, 16'h0000} : {16'h0000, ioctl_dout};
    assign w_sel_merged = r_asm_sel | w_lane_sel;
    assign w_data_merged = ioctl_addr[1] ? {ioctl_dout, r_asm_data[15:0]}
                                         : {r_asm_data[31:16], ioctl_dout};

    // Assembly register and the single FIFO push that an accepted write may cause
    always_comb begin
        w_push        = 1'b0;
        w_push_ent    = {r_asm_word, r_asm_data, r_asm_sel};
        w_asm_word_n  = r_asm_word;
        w_asm_data_n  = r_asm_data;
        w_asm_sel_n   = r_asm_sel;
        w_asm_valid_n = r_asm_valid;
        if (w_acc) begin
            if (!r_asm_valid || (w_word != r_asm_word)) begin
                w_push        = r_asm_valid;
                w_asm_word_n  = w_word;
                w_asm_data_n  = w_lane_data;
                w_asm_sel_n   = w_lane_sel;
                w_asm_valid_n = 1'b1;
            end else if (w_sel_merged == 4'b1111) begin
                w_push        = 1'b1;
                w_push_ent    = {r_asm_word, w_data_merged, 4'b1111};
                w_asm_valid_n = 1'b0;
            end else begin
                w_asm_data_n  = w_data_merged;
                w_asm_sel_n   = w_sel_merged;
            end
        end else if (r_active_q && !r_active && r_asm_valid) begin
            w_push        = 1'b1;
            w_asm_valid_n = 1'b0;
        end
    end

    assign w_empty   = (r_count == '0);
    assign w_do_push = w_push && (r_count != LP_FULL);
    assign w_pop     = (r_state == S_REQ) && wb_ack_i;
    assign w_load    = (r_state == S_IDLE) && !w_empty;
    assign w_head    = r_fifo[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_REQ;
            S_REQ:   if (wb_ack_i) w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (w_do_push) r_fifo[r_wr_ptr] <= w_push_ent;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_active    <= 1'b0;
            r_active_q  <= 1'b0;
            r_asm_word  <= '0;
            r_asm_data  <= '0;
            r_asm_sel   <= '0;
            r_asm_valid <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wb_sel    <= '0;
            r_wb_adr    <= '0;
            r_wb_dat    <= '0;
            r_ww        <= '0;
            r_busy_q    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_active    <= w_active_nxt;
            r_active_q  <= r_active;
            r_asm_word  <= w_asm_word_n;
            r_asm_data  <= w_asm_data_n;
            r_asm_sel   <= w_asm_sel_n;
            r_asm_valid <= w_asm_valid_n;
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Outputs are captured on entry to S_REQ so they stay frozen until ack
            if (w_load) begin
                r_wb_sel <= w_head[3:0];
                r_wb_dat <= w_head[35:4];
                r_wb_adr <= BASE_ADDR + {2'b00, w_head[57:36], 2'b00};
            end
            if (w_active_nxt && !r_active) r_ww <= '0;
            else if (w_pop && (r_ww != '1)) r_ww <= r_ww + 22'd1;
            r_busy_q <= w_busy;
            r_done   <= r_busy_q && !w_busy;
        end
    end

    assign w_busy        = r_active || r_asm_valid || !w_empty || (r_state != S_IDLE);
    assign ioctl_wait    = r_active && (r_count >= LP_WAIT);
    assign wb_cyc_o      = (r_state == S_REQ);
    assign wb_stb_o      = (r_state == S_REQ);
    assign wb_we_o       = (r_state == S_REQ);
    assign wb_sel_o      = r_wb_sel;
    assign wb_adr_o      = r_wb_adr;
    assign wb_dat_o      = r_wb_dat;
    assign wb_cti_o      = 3'b000;
    assign dl_busy       = w_busy;
    assign dl_done       = r_done;
    assign words_written = r_ww;

endmodule
